// File: rtl/pkt_buf_sched.sv
// Store-and-forward packet buffer shared by NUM_REQ requesters under round-robin arbitration.
// One packet is resident at a time: it is filled, optionally truncated at DEPTH words, then drained.
module pkt_buf_sched #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      out_valid_o,
  output logic [DATA_W-1:0]         out_data_o,
  output logic                      out_last_o,
  input  logic                      out_ready_i,
  output logic                      overflow_o,
  output logic                      busy_o
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, FILL, DISCARD, DRAIN} state_e;

  state_e              state_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [IDX_W-1:0]    gidx_q;
  logic [IDX_W-1:0]    last_q;
  logic [CNT_W-1:0]    wr_cnt_q;
  logic [CNT_W-1:0]    rd_ptr_q;
  logic                overflow_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                g_valid;
  logic                g_last;
  logic [DATA_W-1:0]   g_data;
  logic                arb_found;
  logic [IDX_W-1:0]    arb_idx;
  logic                in_fire;
  logic                out_fire;
  logic                drain_last;

  // Select the word stream of the current owner.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (grant_q[r]) begin
        g_valid = req_valid_i[r];
        g_last  = req_last_i[r];
        g_data  = req_data_i[r*DATA_W +: DATA_W];
      end
    end
  end

  // Requesters above the last winner are searched first, then the wrap-around part.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (!arb_found && req_valid_i[r] && (IDX_W'(r) > last_q)) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(r);
      end
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      if (!arb_found && req_valid_i[r] && (IDX_W'(r) <= last_q)) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(r);
      end
    end
  end

  assign in_fire    = g_valid && ((state_q == FILL) || (state_q == DISCARD));
  assign drain_last = (rd_ptr_q == (wr_cnt_q - CNT_W'(1)));
  assign out_fire   = (state_q == DRAIN) && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      wr_cnt_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (arb_found) begin
            grant_q  <= NUM_REQ'(1) << arb_idx;
            gidx_q   <= arb_idx;
            wr_cnt_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= FILL;
          end
        end
        FILL: begin
          if (in_fire) begin
            wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            if (g_last) begin
              state_q <= DRAIN;
            end else if (wr_cnt_q == CNT_W'(DEPTH - 1)) begin
              overflow_q <= 1'b1;
              state_q    <= DISCARD;
            end
          end
        end
        DISCARD: begin
          if (in_fire && g_last) state_q <= DRAIN;
        end
        DRAIN: begin
          if (out_fire) begin
            rd_ptr_q <= rd_ptr_q + CNT_W'(1);
            if (drain_last) begin
              state_q  <= IDLE;
              grant_q  <= '0;
              rd_ptr_q <= '0;
              wr_cnt_q <= '0;
              last_q   <= gidx_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Truncation stores the DEPTH-th word; the counter reaching DEPTH makes it the last one drained.
  always_ff @(posedge clk_i) begin
    if ((state_q == FILL) && in_fire) mem_q[wr_cnt_q[AW-1:0]] <= g_data;
  end

  assign req_ready_o = ((state_q == FILL) || (state_q == DISCARD)) ? grant_q : '0;
  assign grant_o     = grant_q;
  assign out_valid_o = (state_q == DRAIN);
  assign out_data_o  = (state_q == DRAIN) ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign out_last_o  = (state_q == DRAIN) && drain_last;
  assign overflow_o  = overflow_q;
  assign busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_pkt_buf_sched.sv
// Bench for pkt_buf_sched: packet-level reference model (round-robin order, DEPTH truncation)
// compared against the drained stream, grant order and handshake rules.
module tb_pkt_buf_sched;
  localparam int NR = 2;
  localparam int DW = 32;
  localparam int DP = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_last = '0;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     grant;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic              out_ready = 1'b0;
  logic              overflow;
  logic              busy;

  pkt_buf_sched #(.NUM_REQ(NR), .DATA_W(DW), .DEPTH(DP)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready), .grant_o(grant),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_last_o(out_last),
    .out_ready_i(out_ready), .overflow_o(overflow), .busy_o(busy)
  );

  always #5 clk = ~clk;

  logic [DW:0] src_q [NR][$];
  logic [DW:0] mdl_q [NR][$];
  logic [DW:0] exp_q [$];
  logic [DW:0] got_q [$];
  int exp_grant [$];
  int got_grant [$];
  int exp_ovf, model_last;
  int busy_cycles, valid_cycles, ovf_cnt, viol, stall_viol;
  bit timeout;
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic add_pkt(input int r, input int len);
    logic [DW:0] w;
    for (int i = 0; i < len; i++) begin
      w = {(i == len - 1), DW'($urandom)};
      src_q[r].push_back(w);
      mdl_q[r].push_back(w);
    end
  endtask

  // Packets leave in round-robin order among requesters with pending packets; long ones are cut at DP.
  task automatic build_expected();
    int r, c, n;
    logic [DW:0] w;
    exp_q.delete(); exp_grant.delete(); exp_ovf = 0;
    forever begin
      r = -1;
      for (int k = 1; k <= NR; k++) begin
        c = (model_last + k) % NR;
        if (r < 0 && mdl_q[c].size() > 0) r = c;
      end
      if (r < 0) break;
      exp_grant.push_back(r);
      model_last = r;
      n = 0;
      do begin
        w = mdl_q[r].pop_front();
        n++;
        if (n < DP) exp_q.push_back(w);
        else if (n == DP) exp_q.push_back({1'b1, w[DW-1:0]});
      end while (!w[DW]);
      if (n > DP) exp_ovf++;
    end
  endtask

  task automatic run(input int max_cycles, input int stop_after_in, input int rdy_mode);
    int cyc, in_cnt, rc;
    logic prev_stall;
    logic [DW-1:0] prev_data;
    logic [NR-1:0] prev_grant;
    logic [3:0] pat;
    logic all_empty;
    cyc = 0; in_cnt = 0; rc = 0; prev_stall = 0; prev_data = '0; prev_grant = '0; pat = 4'b1001;
    got_q.delete(); got_grant.delete();
    busy_cycles = 0; valid_cycles = 0; ovf_cnt = 0; viol = 0; stall_viol = 0; timeout = 0;
    forever begin
      @(negedge clk);
      for (int r = 0; r < NR; r++) begin
        if (src_q[r].size() > 0) begin
          req_valid[r] = 1'b1;
          req_last[r]  = src_q[r][0][DW];
          req_data[r*DW +: DW] = src_q[r][0][DW-1:0];
        end else begin
          req_valid[r] = 1'b0;
          req_last[r]  = 1'b0;
          req_data[r*DW +: DW] = '0;
        end
      end
      if (rdy_mode == 1 && out_valid) begin
        out_ready = pat[rc % 4];
        rc++;
      end else if (rdy_mode == 2) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = 1'b1;
      if (busy) busy_cycles++;
      if (overflow) ovf_cnt++;
      if (out_valid) valid_cycles++;
      if ((req_ready & ~grant) != '0 || (out_valid && !busy)) viol++;
      if (grant != '0 && !$onehot(grant)) viol++;
      if (grant != '0 && prev_grant == '0)
        for (int r = 0; r < NR; r++) if (grant[r]) got_grant.push_back(r);
      if (prev_stall && (!out_valid || out_data !== prev_data)) stall_viol++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_grant = grant;
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
      for (int r = 0; r < NR; r++)
        if (req_valid[r] && req_ready[r]) begin
          void'(src_q[r].pop_front());
          in_cnt++;
        end
      cyc++;
      all_empty = 1'b1;
      for (int r = 0; r < NR; r++) if (src_q[r].size() > 0) all_empty = 1'b0;
      if (stop_after_in >= 0 && in_cnt >= stop_after_in) break;
      if (stop_after_in < 0 && got_q.size() >= exp_q.size() && all_empty && !busy) break;
      if (cyc >= max_cycles) begin
        timeout = 1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; req_last = '0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_last = NR - 1;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (grant !== '0) $display("FAIL rst_grant got %b want 0", grant); else pass_cnt++;
    total_cnt++; if (req_ready !== '0) $display("FAIL rst_ready got %b want 0", req_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_last !== 1'b0) $display("FAIL rst_out_last got %b want 0", out_last); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL rst_overflow got %b want 0", overflow); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (out_data !== '0) $display("FAIL rst_out_data got %h want 0", out_data); else pass_cnt++;
  endtask

  task automatic test_three_word();
    add_pkt(0, 3);
    build_expected();
    run(200, -1, 0);
    total_cnt++; if (timeout) $display("FAIL three_timeout got 1 want 0"); else pass_cnt++;
    total_cnt++; if (got_q.size() != 3) $display("FAIL three_count got %0d want 3", got_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total_cnt++;
      if (got_q[i] !== exp_q[i]) $display("FAIL three_word[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++; if (busy_cycles != 6) $display("FAIL three_busy_cycles got %0d want 6", busy_cycles); else pass_cnt++;
    total_cnt++; if (viol != 0) $display("FAIL three_handshake got %0d want 0", viol); else pass_cnt++;
  endtask

  task automatic test_single_word();
    add_pkt(0, 1);
    build_expected();
    run(200, -1, 0);
    total_cnt++; if (got_q.size() != 1 || got_q[0] !== exp_q[0])
      $display("FAIL single_word got %h want %h", got_q.size() > 0 ? got_q[0] : '0, exp_q[0]); else pass_cnt++;
    total_cnt++; if (valid_cycles != 1) $display("FAIL single_valid_cycles got %0d want 1", valid_cycles); else pass_cnt++;
    total_cnt++; if (busy_cycles != 2) $display("FAIL single_busy_cycles got %0d want 2", busy_cycles); else pass_cnt++;
  endtask

  task automatic test_alternate();
    do_reset();
    add_pkt(0, 2); add_pkt(0, 2);
    add_pkt(1, 2); add_pkt(1, 2);
    build_expected();
    run(400, -1, 0);
    total_cnt++; if (timeout) $display("FAIL alt_timeout got 1 want 0"); else pass_cnt++;
    total_cnt++; if (got_grant.size() != 4) $display("FAIL alt_grant_count got %0d want 4", got_grant.size()); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (got_grant[i] !== i % 2) $display("FAIL alt_grant[%0d] got %0d want %0d", i, got_grant[i], i % 2);
      else pass_cnt++;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total_cnt++;
      if (got_q[i] !== exp_q[i]) $display("FAIL alt_word[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++; if (viol != 0) $display("FAIL alt_handshake got %0d want 0", viol); else pass_cnt++;
  endtask

  task automatic test_overflow();
    add_pkt(1, 20);
    build_expected();
    run(400, -1, 0);
    total_cnt++; if (got_q.size() != DP) $display("FAIL ovf_count got %0d want %0d", got_q.size(), DP); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total_cnt++;
      if (got_q[i] !== exp_q[i]) $display("FAIL ovf_word[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++; if (ovf_cnt != 1) $display("FAIL ovf_pulses got %0d want 1", ovf_cnt); else pass_cnt++;
    total_cnt++; if (src_q[1].size() != 0) $display("FAIL ovf_consumed got %0d left want 0", src_q[1].size()); else pass_cnt++;
    total_cnt++; if (busy_cycles != 36) $display("FAIL ovf_busy_cycles got %0d want 36", busy_cycles); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    add_pkt(0, 6);
    build_expected();
    run(400, -1, 1);
    total_cnt++; if (got_q.size() != 6) $display("FAIL bp_count got %0d want 6", got_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total_cnt++;
      if (got_q[i] !== exp_q[i]) $display("FAIL bp_word[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++; if (stall_viol != 0) $display("FAIL bp_stall_hold got %0d want 0", stall_viol); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    add_pkt(0, 5);
    mdl_q[0].delete();
    run(100, 2, 0);
    do_reset();
    total_cnt++; if (busy !== 1'b0) $display("FAIL mid_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (grant !== '0) $display("FAIL mid_grant got %b want 0", grant); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (req_ready !== '0) $display("FAIL mid_ready got %b want 0", req_ready); else pass_cnt++;
    src_q[0].delete();
    add_pkt(1, 3);
    build_expected();
    run(200, -1, 0);
    total_cnt++; if (got_q.size() != 3) $display("FAIL mid_count got %0d want 3", got_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total_cnt++;
      if (got_q[i] !== exp_q[i]) $display("FAIL mid_word[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int npk;
    for (int round = 0; round < 6; round++) begin
      for (int r = 0; r < NR; r++) begin
        npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++) add_pkt(r, $urandom_range(1, 20));
      end
      if (mdl_q[0].size() == 0 && mdl_q[1].size() == 0) add_pkt(0, $urandom_range(1, 20));
      build_expected();
      run(4000, -1, 2);
      total_cnt++; if (timeout) $display("FAIL rnd%0d_timeout got 1 want 0", round); else pass_cnt++;
      total_cnt++; if (got_q.size() != exp_q.size())
        $display("FAIL rnd%0d_count got %0d want %0d", round, got_q.size(), exp_q.size()); else pass_cnt++;
      for (int i = 0; i < exp_q.size(); i++) begin
        total_cnt++;
        if (got_q[i] !== exp_q[i]) $display("FAIL rnd%0d_word[%0d] got %h want %h", round, i, got_q[i], exp_q[i]);
        else pass_cnt++;
      end
      total_cnt++; if (got_grant != exp_grant) $display("FAIL rnd%0d_grant_order got %p want %p", round, got_grant, exp_grant); else pass_cnt++;
      total_cnt++; if (ovf_cnt != exp_ovf) $display("FAIL rnd%0d_overflow got %0d want %0d", round, ovf_cnt, exp_ovf); else pass_cnt++;
      total_cnt++; if (viol != 0 || stall_viol != 0)
        $display("FAIL rnd%0d_handshake got %0d/%0d want 0/0", round, viol, stall_viol); else pass_cnt++;
    end
  endtask

  initial begin
    model_last = NR - 1;
    test_reset();
    test_three_word();
    test_single_word();
    test_alternate();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
